// File: rtl/hog_pkg.sv
// hog_pkg -- shared constants for the HOG cell histogram blocks.
//   NBINS          : orientation bins per cell histogram (codes 0..8)
//   HOG_*          : default widths / cell size used by cell_hist_acc
//   ST_ACC/DRAIN   : FSM state encodings of cell_hist_acc
package hog_pkg;

    localparam int NBINS       = 9;

    localparam int HOG_CODE_W  = 4;
    localparam int HOG_MAG_W   = 16;
    localparam int HOG_CNT_W   = 6;
    localparam int HOG_MAX_CNT = 64;
    localparam int HOG_BIN_W   = HOG_MAG_W + HOG_CNT_W;

    typedef logic [0:0] hog_state_t;

    localparam hog_state_t ST_ACC   = 1'b0;
    localparam hog_state_t ST_DRAIN = 1'b1;

endpackage

// File: rtl/hist_bank.sv
// hist_bank -- one bank of NBINS orientation-bin accumulators.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset, clears every bin
//   add_en   : add add_mag (zero-extended) into bin[add_code] this edge
//   add_code : target bin; codes >= NBINS are ignored
//   add_mag  : unsigned magnitude
//   clr      : zero every bin this edge (wins over add_en)
//   rd_idx   : combinational read index
//   rd_data  : bin[rd_idx], or 0 for an out-of-range index
module hist_bank
    import hog_pkg::*;
#(
    parameter int CODE_W = HOG_CODE_W,
    parameter int MAG_W  = HOG_MAG_W,
    parameter int BIN_W  = HOG_BIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add_en,
    input  logic [CODE_W-1:0] add_code,
    input  logic [MAG_W-1:0]  add_mag,
    input  logic              clr,
    input  logic [CODE_W-1:0] rd_idx,
    output logic [BIN_W-1:0]  rd_data
);

    logic [BIN_W-1:0] bin_q [NBINS];
    logic [BIN_W-1:0] bin_d [NBINS];

    always_comb begin
        for (int i = 0; i < NBINS; i++) begin
            bin_d[i] = bin_q[i];
        end
        if (clr) begin
            for (int i = 0; i < NBINS; i++) begin
                bin_d[i] = '0;
            end
        end else if (add_en) begin
            // Out-of-range codes match no bin, so they fall through untouched.
            for (int i = 0; i < NBINS; i++) begin
                if (add_code == CODE_W'(i)) begin
                    bin_d[i] = bin_q[i] + BIN_W'(add_mag);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBINS; i++) begin
                bin_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBINS; i++) begin
                bin_q[i] <= bin_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NBINS; i++) begin
            if (rd_idx == CODE_W'(i)) begin
                rd_data = bin_q[i];
            end
        end
    end

endmodule

// File: rtl/cell_hist_acc.sv
// cell_hist_acc -- accumulates MAX_CNT pixel samples into a 9-bin
// orientation histogram, then streams the bins out as 9 beats.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   i_valid/i_ready: sample handshake; i_code selects the bin, i_mag is added
//   o_valid/o_ready: beat handshake; o_idx = bin index, o_bin = bin value,
//                    o_last high on the idx-8 beat
// Build option HIST_DBUF_EN: two banks, so a new cell accumulates while the
// previous one drains. Without it one bank is used and input stalls in DRAIN.
module cell_hist_acc
    import hog_pkg::*;
#(
    parameter int CODE_W  = HOG_CODE_W,
    parameter int MAG_W   = HOG_MAG_W,
    parameter int CNT_W   = HOG_CNT_W,
    parameter int MAX_CNT = HOG_MAX_CNT,
    parameter int BIN_W   = MAG_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [CODE_W-1:0] i_code,
    input  logic [MAG_W-1:0]  i_mag,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [BIN_W-1:0]  o_bin,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_last
);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CNT - 1);
    localparam logic [CODE_W-1:0] IDX_LAST = CODE_W'(NBINS - 1);

    hog_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              o_valid_q, o_valid_d;
    logic [CODE_W-1:0] o_idx_q, o_idx_d;
    logic [BIN_W-1:0]  rd_sel;

    logic accept, complete, beat_hs, last_hs;

    assign accept   = i_valid && i_ready;
    assign complete = accept && (cnt_q == CNT_LAST);
    assign beat_hs  = o_valid_q && o_ready;
    assign last_hs  = beat_hs && (o_idx_q == IDX_LAST);

    // Every accepted sample counts, including out-of-range codes.
    always_comb begin
        cnt_d = cnt_q;
        if (complete) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef HIST_DBUF_EN
    // acc_sel_q: bank currently accumulating; the other bank is the one drained.
    // pend_q: the accumulating bank filled while the other was still draining.
    logic acc_sel_q, acc_sel_d;
    logic pend_q, pend_d;
    logic [BIN_W-1:0] rd0, rd1;

    assign i_ready = !pend_q;

    always_comb begin
        state_d   = state_q;
        o_valid_d = o_valid_q;
        o_idx_d   = o_idx_q;
        acc_sel_d = acc_sel_q;
        pend_d    = pend_q;
        case (state_q)
            ST_ACC: begin
                if (complete) begin
                    state_d   = ST_DRAIN;
                    o_valid_d = 1'b1;
                    o_idx_d   = '0;
                    acc_sel_d = !acc_sel_q;
                end
            end
            default: begin
                if (last_hs) begin
                    o_idx_d = '0;
                    if (pend_q || complete) begin
                        // Full bank waiting: swap and start draining it at once;
                        // the bank just cleared becomes the accumulator.
                        acc_sel_d = !acc_sel_q;
                        pend_d    = 1'b0;
                    end else begin
                        state_d   = ST_ACC;
                        o_valid_d = 1'b0;
                    end
                end else begin
                    if (beat_hs) begin
                        o_idx_d = o_idx_q + CODE_W'(1);
                    end
                    if (complete) begin
                        pend_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_sel_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            acc_sel_q <= acc_sel_d;
            pend_q    <= pend_d;
        end
    end

    hist_bank #(.CODE_W(CODE_W), .MAG_W(MAG_W), .BIN_W(BIN_W)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .add_en   (accept && !acc_sel_q),
        .add_code (i_code),
        .add_mag  (i_mag),
        .clr      (last_hs && acc_sel_q),
        .rd_idx   (o_idx_q),
        .rd_data  (rd0)
    );

    hist_bank #(.CODE_W(CODE_W), .MAG_W(MAG_W), .BIN_W(BIN_W)) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .add_en   (accept && acc_sel_q),
        .add_code (i_code),
        .add_mag  (i_mag),
        .clr      (last_hs && !acc_sel_q),
        .rd_idx   (o_idx_q),
        .rd_data  (rd1)
    );

    assign rd_sel = acc_sel_q ? rd0 : rd1;
`else
    logic [BIN_W-1:0] rd0;

    assign i_ready = (state_q == ST_ACC);

    always_comb begin
        state_d   = state_q;
        o_valid_d = o_valid_q;
        o_idx_d   = o_idx_q;
        case (state_q)
            ST_ACC: begin
                if (complete) begin
                    state_d   = ST_DRAIN;
                    o_valid_d = 1'b1;
                    o_idx_d   = '0;
                end
            end
            default: begin
                if (last_hs) begin
                    state_d   = ST_ACC;
                    o_valid_d = 1'b0;
                    o_idx_d   = '0;
                end else if (beat_hs) begin
                    o_idx_d = o_idx_q + CODE_W'(1);
                end
            end
        endcase
    end

    hist_bank #(.CODE_W(CODE_W), .MAG_W(MAG_W), .BIN_W(BIN_W)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .add_en   (accept),
        .add_code (i_code),
        .add_mag  (i_mag),
        .clr      (last_hs),
        .rd_idx   (o_idx_q),
        .rd_data  (rd0)
    );

    assign rd_sel = rd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_idx_q   <= o_idx_d;
        end
    end

    // The drained bank is frozen while beats are pending, so the read is stable
    // under back-pressure; outside a drain o_bin is forced to zero.
    assign o_valid = o_valid_q;
    assign o_idx   = o_idx_q;
    assign o_bin   = o_valid_q ? rd_sel : '0;
    assign o_last  = o_valid_q && (o_idx_q == IDX_LAST);

endmodule

// File: doc/cell_hist_acc.md
CELL_HIST_ACC -- requirements
Module: cell_hist_acc

Interface
REQ-001 SHALL have parameter CODE_W, default 4, orientation code width.
REQ-002 SHALL have parameter MAG_W, default 16, unsigned gradient magnitude width.
REQ-003 SHALL have parameter CNT_W, default 6, pixel counter width.
REQ-004 SHALL have parameter MAX_CNT, default 64, pixels per cell.
REQ-005 SHALL have parameter BIN_W, default MAG_W+CNT_W (22), bin accumulator width.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_valid, input, 1, pixel sample valid.
REQ-009 SHALL have port i_ready, output, 1, sample accepted when i_valid && i_ready.
REQ-010 SHALL have port i_code, input, CODE_W, orientation bin code 0..8.
REQ-011 SHALL have port i_mag, input, MAG_W, unsigned magnitude.
REQ-012 SHALL have port o_valid, output, 1, histogram beat valid.
REQ-013 SHALL have port o_ready, input, 1, downstream accepts beat when o_valid && o_ready.
REQ-014 SHALL have port o_bin, output, BIN_W, accumulated bin value.
REQ-015 SHALL have port o_idx, output, CODE_W, bin index 0..8 of current beat.
REQ-016 SHALL have port o_last, output, 1, high on beat with o_idx==8.

Function
REQ-017 SHALL keep 9 bin accumulators per bank and a CNT_W pixel counter.
REQ-018 SHALL, on each accepted sample with i_code<=8, add zero-extended i_mag to bin[i_code] in the next cycle.
REQ-019 SHALL count but not accumulate accepted samples with i_code>=9.
REQ-020 SHALL mark a cell complete on the MAX_CNT-th accepted sample, counter wrapping to 0.
REQ-021 SHALL have FSM states ACC and DRAIN: ACC->DRAIN on cell complete; DRAIN->ACC after handshake of o_last beat.
REQ-022 SHALL assert o_valid with o_idx=0 the cycle after the completing sample is accepted (latency 1 cycle), including that sample's magnitude.
REQ-023 SHALL emit indices 0..8 in order, advancing o_idx only on o_valid && o_ready.
REQ-024 SHALL hold o_bin, o_idx, o_last stable while o_valid && !o_ready.
REQ-025 SHALL clear the drained bank to zero upon the o_last handshake.
REQ-026 SHALL never overflow: BIN_W covers MAX_CNT*(2^MAG_W-1); no saturation logic.

Reset
REQ-027 SHALL, on rst low, asynchronously set FSM=ACC, counter=0, all bins=0, o_valid=0, o_idx=0, o_last=0, o_bin=0, i_ready=1.
REQ-028 SHALL discard any partial cell or in-progress drain on reset mid-operation; no beat emitted after release until a new full cell.

Configuration
REQ-029 SHALL, with macro HIST_DBUF_EN defined, use two banks: accumulation switches banks on cell complete and continues during DRAIN; i_ready drops only if the accumulating bank completes while the other is still draining, and rises the cycle after that drain's o_last handshake.
REQ-030 SHALL, without HIST_DBUF_EN, use one bank; i_ready=0 throughout DRAIN and the completing cycle's successor, returning to 1 the cycle after the o_last handshake.

Structure
REQ-031 SHALL place NBINS=9, default widths and FSM state encodings in shared package hog_pkg.
REQ-032 SHALL instantiate one sub-module hist_bank (9 accumulators, add port, read-by-index port, clear) once, or twice under HIST_DBUF_EN.

Verification
REQ-033 SHALL cover: 64 samples code=3 mag=100 -> beats idx0..8, idx3=6400, others 0, o_last on idx8.
REQ-034 SHALL cover: 64 samples code=k%9 mag=1 (k=0..63) -> bins 0 to 0 =8, bins 1..8 =7 each.
REQ-035 SHALL cover: 64 samples code=12 mag=500 -> all 9 bins 0, cell still drained.
REQ-036 SHALL cover: 64 samples mag=65535 code=8 -> bin8=4194240, no wrap.
REQ-037 SHALL cover: o_ready held low 10 cycles on idx4 -> outputs stable; without HIST_DBUF_EN i_ready=0 throughout; with it, next cell accepted and correct.
REQ-038 SHALL cover: rst pulsed after 30 samples -> no beat; next 64 samples (mag=2, code=0) yield bin0=128.
